// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the UART transmitter and the arbiter.
// The arbiter side uses the slave modport; the requester/transmitter side uses master.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic               busy_flag;
    logic               err;

    modport master (
        output req, req_data, busy_flag,
        input  ack, grant, tx_data, tx_ready, err
    );

    modport slave (
        input  req, req_data, busy_flag,
        output ack, grant, tx_data, tx_ready, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no owner; arbitrate on the req value sampled this cycle
// START     | one-cycle tx_ready strobe to the transmitter
// WAIT_BUSY | wait for busy_flag to rise, bounded by TIMEOUT cycles
// WAIT_DONE | frame in progress; release the owner when busy_flag falls
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               s_clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_ready_q, tx_ready_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;

    logic [PTR_W-1:0]   sel_idx;
    logic [N_REQ-1:0]   sel_gnt;
    logic [7:0]         sel_data;
    logic               sel_vld;
    logic [CNT_W-1:0]   cnt_inc;
    int                 idx;

    // Round-robin pick: walk offsets from N_REQ down to 1 so the smallest
    // offset above last_ptr (the first set bit searching upward) wins.
    always_comb begin
        sel_idx  = '0;
        sel_gnt  = '0;
        sel_data = '0;
        sel_vld  = 1'b0;
        idx      = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_ptr_q) + k) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == idx && bus.req[i]) begin
                    sel_idx    = PTR_W'(i);
                    sel_gnt    = '0;
                    sel_gnt[i] = 1'b1;
                    sel_data   = bus.req_data[8*i +: 8];
                    sel_vld    = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        err_d      = 1'b0;
        tx_ready_d = 1'b0;
        cnt_inc    = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d    = sel_gnt;
                    tx_data_d  = sel_data;
                    owner_d    = sel_idx;
                    cnt_d      = '0;
                    tx_ready_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.busy_flag) begin
                    ack_d   = grant_q;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        // Transmitter never started: drop this owner and
                        // advance the pointer so the next requester gets a turn.
                        err_d      = 1'b1;
                        grant_d    = '0;
                        last_ptr_d = owner_q;
                        state_d    = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.busy_flag) begin
                    grant_d    = '0;
                    last_ptr_d = owner_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset leaves requester 0 first in line.
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_ready_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            last_ptr_q <= PTR_W'(N_REQ - 1);
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
            owner_q    <= owner_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.err      = err_q;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter TIMEOUT, default 16: s_clk cycles allowed for the transmitter busy_flag to rise after a start.
REQ-003 s_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester send request, level; held until that requester's ack.
REQ-006 req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i], held stable while req[i]=1.
REQ-007 ack  output  N_REQ  one-cycle pulse to the requester whose byte the transmitter accepted.
REQ-008 grant  output  N_REQ  one-hot current owner of the transmitter, all-zero when idle.
REQ-009 tx_data  output  8  byte presented to the transmitter data input.
REQ-010 tx_ready  output  1  one-cycle start strobe to the transmitter.
REQ-011 busy_flag  input  1  transmitter busy indication, high while a frame is in progress.
REQ-012 err  output  1  one-cycle pulse when a start times out.

Function
REQ-013 The FSM SHALL have states IDLE, START, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-014 In IDLE with any req bit set, the next edge SHALL select the first set bit searching upward (with wrap) from last_ptr+1, load grant, load tx_data from that requester's slice, and enter START.
REQ-015 In IDLE with req all-zero, the state, grant (0) and tx_data SHALL hold.
REQ-016 START SHALL last exactly one cycle with tx_ready=1, then enter WAIT_BUSY; tx_ready SHALL be 0 in every other state.
REQ-017 In WAIT_BUSY with busy_flag=1, the next edge SHALL pulse ack for the granted bit for one cycle and enter WAIT_DONE.
REQ-018 In WAIT_BUSY with busy_flag=0, a cycle counter SHALL increment; when it reaches TIMEOUT, the FSM SHALL pulse err for one cycle, give no ack, clear grant, set last_ptr to the granted index, and return to IDLE.
REQ-019 In WAIT_DONE, busy_flag=0 SHALL clear grant, set last_ptr to the granted index, and return to IDLE; the FSM SHALL NOT accept a new request in that same cycle.
REQ-020 Minimum spacing between consecutive grants SHALL therefore be 1 idle cycle after busy_flag falls.
REQ-021 The timeout counter SHALL clear on entry to START and SHALL be wide enough to hold TIMEOUT without wrap.
REQ-022 A requester dropping req after grant SHALL NOT abort the transaction; the latched tx_data SHALL be sent and ack still pulsed.
REQ-023 req_data changes after grant SHALL NOT affect tx_data.
REQ-024 New req bits arriving outside IDLE SHALL wait; arbitration uses only the req value sampled in IDLE.
REQ-025 Round-robin SHALL guarantee that a continuously asserted req[i] is granted within N_REQ transactions.
REQ-026 ack and err SHALL never both be high, and at most one ack bit SHALL be high in any cycle.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, grant=0, ack=0, tx_ready=0, err=0, tx_data=8'h00, counter=0, and last_ptr=N_REQ-1, so requester 0 has priority first.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no ack or err; after release, the FSM SHALL re-arbitrate from IDLE.

Verification
REQ-029 Single requester: req=4'b0100, data2=8'hA5, busy_flag rising 2 cycles after tx_ready -> grant=4'b0100, tx_data=8'hA5, one tx_ready pulse, ack=4'b0100 one cycle, return to IDLE after busy_flag falls.
REQ-030 Round-robin: req=4'b1111 held, each ack followed by that bit dropping and re-asserting -> grant order 0,1,2,3,0.
REQ-031 Timeout: busy_flag held 0 -> err pulse exactly TIMEOUT cycles after WAIT_BUSY entry, ack=0, next grant goes to the next requester.
REQ-032 Data stability: req_data0 changed from 8'h3C to 8'hFF after grant -> tx_data stays 8'h3C through WAIT_DONE.
REQ-033 Reset mid-transaction: rst pulsed in WAIT_DONE -> all outputs zero at once, no ack, and with req=4'b0010 after release grant=4'b0010.
REQ-034 Late arrival: req[3] asserted during WAIT_DONE of requester 1 -> requester 3 granted in the first IDLE cycle after busy_flag falls.
